// File: rtl/logic_sweep_checker_pkg.sv
// Shared types, f_in bit positions and golden truth functions for the logic sweep checker.
package logic_sweep_checker_pkg;

    localparam int unsigned ABC_W = 3;
    localparam int unsigned F_W   = 6;

    localparam int unsigned F1_IDX = 0;
    localparam int unsigned F2_IDX = 1;
    localparam int unsigned F3_IDX = 2;
    localparam int unsigned F4_IDX = 3;
    localparam int unsigned F5_IDX = 4;
    localparam int unsigned F7_IDX = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected unit outputs for a given abc (a = bit2, c = bit0).
    function automatic logic [F_W-1:0] golden_f(input logic [ABC_W-1:0] abc);
        logic a;
        logic b;
        logic c;
        logic [F_W-1:0] g;
        a = abc[2];
        b = abc[1];
        c = abc[0];
        g = '0;
        g[F1_IDX] = a & b;
        g[F2_IDX] = a & c;
        g[F3_IDX] = (a & b) | (b & c) | (a & c);
        g[F4_IDX] = (~a & b) | (a & c);
        g[F5_IDX] = a | (b & ~c);
        g[F7_IDX] = ~a & ~b & c;
        return g;
    endfunction

endpackage

// File: rtl/logic_sweep_checker_if.sv
// Stimulus/response and result signals between the sweep checker and the unit under test.
interface logic_sweep_checker_if #(
    parameter int unsigned ERR_W = 4
);
    logic                                         start;
    logic [logic_sweep_checker_pkg::F_W-1:0]      f_in;
    logic [logic_sweep_checker_pkg::ABC_W-1:0]    abc_out;
    logic                                         busy;
    logic                                         done;
    logic                                         pass;
    logic [ERR_W-1:0]                             err_count;
    logic [logic_sweep_checker_pkg::ABC_W-1:0]    first_err_vec;
    logic [logic_sweep_checker_pkg::F_W-1:0]      first_err_mask;

    modport master (
        input  start, f_in,
        output abc_out, busy, done, pass, err_count, first_err_vec, first_err_mask
    );

    modport slave (
        output start, f_in,
        input  abc_out, busy, done, pass, err_count, first_err_vec, first_err_mask
    );
endinterface

// File: rtl/logic_golden_ref.sv
// Purely combinational golden model of the 3-input, 6-output logic unit.
module logic_golden_ref
    import logic_sweep_checker_pkg::*;
(
    input  logic [ABC_W-1:0] abc,
    output logic [F_W-1:0]   golden_c
);
    assign golden_c = golden_f(abc);
endmodule

// File: rtl/logic_sweep_checker.sv
// Sweeps abc through an ascending truth table, samples the unit after a settle interval
// and scores each sample against the golden functions.
module logic_sweep_checker
    import logic_sweep_checker_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    logic_sweep_checker_if.master  bus
);
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ABC_W-1:0] LAST_ABC    = ABC_W'(NUM_VECTORS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state_q, state_d;
    logic [ABC_W-1:0] abc_q, abc_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ABC_W-1:0] vec_q, vec_d;
    logic [F_W-1:0]   mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [F_W-1:0]   golden_c;
    logic [F_W-1:0]   mask_c;

    logic_golden_ref u_golden (
        .abc      (abc_q),
        .golden_c (golden_c)
    );

    assign mask_c = golden_c ^ bus.f_in;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            abc_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            vec_q    <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            abc_q    <= abc_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic; start is only honoured when no sweep is running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_SETTLE;
            ST_SETTLE:        if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE:        state_d = (abc_q == LAST_ABC) ? ST_DONE : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Datapath and flag next values
    always_comb begin
        abc_d    = abc_q;
        settle_d = settle_q;
        err_d    = err_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    abc_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    vec_d    = '0;
                    mask_d   = '0;
                end
            end
            ST_SETTLE: settle_d = settle_q + SET_W'(1);
            ST_SAMPLE: begin
                if (mask_c != '0) begin
                    // err_q is still zero only until the first mismatch of the sweep
                    if (err_q == '0) begin
                        vec_d  = abc_q;
                        mask_d = mask_c;
                    end
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                end
                if (abc_q != LAST_ABC) begin
                    abc_d    = abc_q + ABC_W'(1);
                    settle_d = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    assign bus.abc_out        = abc_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_err_vec  = vec_q;
    assign bus.first_err_mask = mask_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Table-driven, scoreboard-checked bench for logic_sweep_checker with a fault-injecting unit model.
module tb_logic_sweep_checker;

    typedef struct {
        int          mode;
        int          exp_err;
        logic [2:0]  exp_vec;
        logic [5:0]  exp_mask;
        int          exp_pass;
    } vec_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_cmp;
    int   n_bad;
    vec_t sb[$];
    vec_t tbl[6];

    logic_sweep_checker_if #(.ERR_W(4)) bus1 ();
    logic_sweep_checker_if #(.ERR_W(2)) bus2 ();

    logic_sweep_checker #(.NUM_VECTORS(8), .SETTLE_CYCLES(2), .ERR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic_sweep_checker #(.NUM_VECTORS(7), .SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived truth table of a correct unit, bit0=f1 .. bit5=f7
    function automatic logic [5:0] tt(input logic [2:0] v);
        case (v)
            3'd0:    return 6'b000000;
            3'd1:    return 6'b100000;
            3'd2:    return 6'b011000;
            3'd3:    return 6'b001100;
            3'd4:    return 6'b010000;
            3'd5:    return 6'b011110;
            3'd6:    return 6'b010101;
            default: return 6'b011111;
        endcase
    endfunction

    // Unit model with selectable faults
    function automatic logic [5:0] unit_out(input logic [2:0] v, input int m);
        case (m)
            1:       return tt(v) & 6'b011111;
            2:       return 6'b000000;
            3:       return ~tt(v);
            4:       return tt(v) | 6'b000001;
            default: return tt(v);
        endcase
    endfunction

    always_comb bus1.f_in = unit_out(bus1.abc_out, mode);
    assign bus2.f_in = 6'b000000;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_sweep(input vec_t v, input int restart_at);
        int   lat;
        vec_t e;
        mode = v.mode;
        @(negedge clk);
        bus1.start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 bus1.start = 1'b0;
        chk("busy_after_start", int'(bus1.busy), 1);
        chk("done_cleared", int'(bus1.done), 0);
        lat = 0;
        while (!bus1.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            bus1.start = (lat == restart_at);
        end
        bus1.start = 1'b0;
        chk("latency", lat, 24);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("err_count", int'(bus1.err_count), e.exp_err);
            chk("first_err_vec", int'(bus1.first_err_vec), int'(e.exp_vec));
            chk("first_err_mask", int'(bus1.first_err_mask), int'(e.exp_mask));
            chk("pass", int'(bus1.pass), e.exp_pass);
            chk("busy_at_done", int'(bus1.busy), 0);
            chk("last_abc", int'(bus1.abc_out), 7);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_abc"}, int'(bus1.abc_out), 0);
        chk({nm, "_busy"}, int'(bus1.busy), 0);
        chk({nm, "_done"}, int'(bus1.done), 0);
        chk({nm, "_pass"}, int'(bus1.pass), 0);
        chk({nm, "_err"}, int'(bus1.err_count), 0);
        chk({nm, "_vec"}, int'(bus1.first_err_vec), 0);
        chk({nm, "_mask"}, int'(bus1.first_err_mask), 0);
    endtask

    initial begin
        int   lat;
        vec_t clean;
        n_cmp = 0;
        n_bad = 0;
        mode  = 0;
        rst_n = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;

        tbl[0] = '{mode: 0, exp_err: 0, exp_vec: 3'd0, exp_mask: 6'b000000, exp_pass: 1};
        tbl[1] = '{mode: 1, exp_err: 1, exp_vec: 3'd1, exp_mask: 6'b100000, exp_pass: 0};
        tbl[2] = '{mode: 2, exp_err: 7, exp_vec: 3'd1, exp_mask: 6'b100000, exp_pass: 0};
        tbl[3] = '{mode: 3, exp_err: 8, exp_vec: 3'd0, exp_mask: 6'b111111, exp_pass: 0};
        tbl[4] = '{mode: 4, exp_err: 6, exp_vec: 3'd0, exp_mask: 6'b000001, exp_pass: 0};
        tbl[5] = '{mode: 0, exp_err: 0, exp_vec: 3'd0, exp_mask: 6'b000000, exp_pass: 1};
        clean = tbl[0];

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_busy", int'(bus1.busy), 0);

        // Back-to-back sweeps, each started from DONE
        for (int i = 0; i < 6; i++) do_sweep(tbl[i], -1);

        // start re-pulsed mid-sweep must be ignored
        do_sweep(tbl[2], 5);

        // Asynchronous reset in the middle of a failing sweep
        mode = 2;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("mid_err", int'(bus1.err_count), 2);
        chk("mid_abc", int'(bus1.abc_out), 3);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 chk("reset_hold_busy", int'(bus1.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_sweep(clean, -1);

        // Short sweep with a narrow saturating counter
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        lat = 0;
        while (!bus2.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("nv7_latency", lat, 21);
        chk("nv7_err_sat", int'(bus2.err_count), 3);
        chk("nv7_last_abc", int'(bus2.abc_out), 6);
        chk("nv7_vec", int'(bus2.first_err_vec), 1);
        chk("nv7_mask", int'(bus2.first_err_mask), 32);
        chk("nv7_pass", int'(bus2.pass), 0);
        repeat (4) @(posedge clk);
        #1 chk("nv7_abc_hold", int'(bus2.abc_out), 6);
        chk("nv7_done_hold", int'(bus2.done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
